// File: rtl/crt_frame_capture_pkg.sv
// -----------------------------------------------------------------------------
// crt_frame_capture_pkg
// Purpose : shared constants and types for the CRT receive path.
//           CRT_WIDTH / CRT_HEIGHT are the screen geometry shared with the
//           CRT transmitter; state_t is the capture/readout state encoding.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package crt_frame_capture_pkg;

  localparam int unsigned CRT_WIDTH  = 40;
  localparam int unsigned CRT_HEIGHT = 6;
  localparam int unsigned CRT_CW     = 6;   // column counter width
  localparam int unsigned CRT_RW     = 3;   // row counter width
  localparam int unsigned LIT_W      = 9;   // 40*6 = 240 lit pixels max

  typedef enum logic {
    ST_CAPTURE = 1'b0,
    ST_READOUT = 1'b1
  } state_t;

endpackage

// File: rtl/crt_row_deserializer.sv
// -----------------------------------------------------------------------------
// crt_row_deserializer
// Purpose : collects one pixel per enabled clock into a WIDTH-bit row word.
//           Pixels enter at the LSB and move left, so after WIDTH pixels the
//           first (leftmost) pixel sits in the MSB.
// Ports   : clk, rst          - clock, asynchronous active-high reset
//           i_shift_en        - accept i_pixel this cycle
//           i_pixel           - 1 = lit
//           o_row_word        - completed row including the current pixel
//           o_row_strobe      - high in the cycle the last column is accepted;
//                               o_row_word is valid during that cycle
// -----------------------------------------------------------------------------
module crt_row_deserializer
  import crt_frame_capture_pkg::*;
#(
  parameter int unsigned WIDTH = CRT_WIDTH,
  parameter int unsigned CW    = CRT_CW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_shift_en,
  input  logic             i_pixel,
  output logic [WIDTH-1:0] o_row_word,
  output logic             o_row_strobe
);

  // Only WIDTH-1 history bits are kept: the newest pixel completes the word
  // combinationally, which lets the top write the buffer on the same edge.
  logic [WIDTH-2:0] r_shift;
  logic [CW-1:0]    r_col;
  logic             w_last_col;

  assign w_last_col   = (r_col == CW'(WIDTH - 1));
  assign o_row_word   = {r_shift, i_pixel};
  assign o_row_strobe = i_shift_en & w_last_col;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= '0;
      r_col   <= '0;
    end else if (i_shift_en) begin
      r_shift <= o_row_word[WIDTH-2:0];
      r_col   <= w_last_col ? '0 : r_col + CW'(1);
    end
  end

endmodule

// File: rtl/crt_frame_capture.sv
// -----------------------------------------------------------------------------
// crt_frame_capture
// Purpose : receive end of the CRT pixel stream. Captures one HEIGHT x WIDTH
//           frame of 1-bit pixels, then offers it row by row over valid/ready.
// Ports   : clk, rst          - pixel clock, asynchronous active-high reset
//           i_pixel_valid     - qualifies i_pixel this cycle
//           i_pixel           - 1 = lit
//           o_row_valid       - o_row_data / o_row_index valid
//           i_row_ready       - reader accepts the row on valid & ready
//           o_row_data        - column c at bit WIDTH-1-c
//           o_row_index       - row number of o_row_data
//           o_frame_done      - one-cycle pulse after the last pixel of a frame
//           o_lit_count       - lit pixels in the last completed frame
//           o_overrun         - sticky: a pixel arrived during readout
// -----------------------------------------------------------------------------
module crt_frame_capture
  import crt_frame_capture_pkg::*;
#(
  parameter int unsigned WIDTH  = CRT_WIDTH,
  parameter int unsigned HEIGHT = CRT_HEIGHT,
  parameter int unsigned CW     = CRT_CW,
  parameter int unsigned RW     = CRT_RW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_pixel_valid,
  input  logic             i_pixel,
  output logic             o_row_valid,
  input  logic             i_row_ready,
  output logic [WIDTH-1:0] o_row_data,
  output logic [RW-1:0]    o_row_index,
  output logic             o_frame_done,
  output logic [LIT_W-1:0] o_lit_count,
  output logic             o_overrun
);

  state_t             r_state;
  state_t             w_state_next;

  logic               w_cap_en;
  logic [WIDTH-1:0]   w_row_word;
  logic               w_row_strobe;
  logic               w_last_row;
  logic               w_frame_end;
  logic               w_handshake;
  logic               w_last_out;
  logic               w_rd_en;
  logic [RW-1:0]      w_rd_addr;

  logic [RW-1:0]      r_row;
  logic [WIDTH-1:0]   r_buf [HEIGHT];
  logic [WIDTH-1:0]   r_row_data;
  logic [RW-1:0]      r_row_index;
  logic               r_row_valid;
  logic               r_frame_done;
  logic [LIT_W-1:0]   r_lit_acc;
  logic [LIT_W-1:0]   r_lit_count;
  logic               r_overrun;

  // Pixels are only consumed while capturing; during readout they are dropped.
  assign w_cap_en    = (r_state == ST_CAPTURE) & i_pixel_valid;
  assign w_last_row  = (r_row == RW'(HEIGHT - 1));
  assign w_frame_end = w_row_strobe & w_last_row;
  assign w_handshake = r_row_valid & i_row_ready;
  assign w_last_out  = w_handshake & (r_row_index == RW'(HEIGHT - 1));

  crt_row_deserializer #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_deser (
    .clk          (clk),
    .rst          (rst),
    .i_shift_en   (w_cap_en),
    .i_pixel      (i_pixel),
    .o_row_word   (w_row_word),
    .o_row_strobe (w_row_strobe)
  );

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_CAPTURE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state plus the buffer read request. Row 0 is fetched on the final
  // pixel so it is presented with one cycle of latency; each handshake fetches
  // the following row so back-to-back readout runs at one row per cycle.
  always_comb begin
    w_state_next = r_state;
    w_rd_en      = 1'b0;
    w_rd_addr    = '0;
    case (r_state)
      ST_CAPTURE: begin
        if (w_frame_end) begin
          w_state_next = ST_READOUT;
          w_rd_en      = 1'b1;
          w_rd_addr    = '0;
        end
      end
      ST_READOUT: begin
        if (w_last_out) begin
          w_state_next = ST_CAPTURE;
        end else if (w_handshake) begin
          w_rd_en   = 1'b1;
          w_rd_addr = r_row_index + RW'(1);
        end
      end
      default: begin
        w_state_next = ST_CAPTURE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Frame buffer: write-only port here, contents are not reset
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_row_strobe) begin
      r_buf[r_row] <= w_row_word;
    end
  end

  // ---------------------------------------------------------------------------
  // Row counter (capture side)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row <= '0;
    end else if (w_row_strobe) begin
      r_row <= w_last_row ? '0 : r_row + RW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Readout: registered buffer read, held while the reader stalls
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row_data  <= '0;
      r_row_index <= '0;
      r_row_valid <= 1'b0;
    end else begin
      if (w_rd_en) begin
        r_row_data <= r_buf[w_rd_addr];
      end
      if (w_frame_end) begin
        r_row_valid <= 1'b1;
        r_row_index <= '0;
      end else if (w_last_out) begin
        r_row_valid <= 1'b0;
        r_row_index <= '0;
      end else if (w_handshake) begin
        r_row_index <= r_row_index + RW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Lit counter, frame_done, overrun
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lit_acc    <= '0;
      r_lit_count  <= '0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_frame_done <= w_frame_end;
      if (w_cap_en) begin
        if (w_frame_end) begin
          // The final pixel itself is folded into the published count.
          r_lit_count <= r_lit_acc + LIT_W'(i_pixel);
          r_lit_acc   <= '0;
        end else begin
          r_lit_acc   <= r_lit_acc + LIT_W'(i_pixel);
        end
      end
      if ((r_state == ST_READOUT) && i_pixel_valid) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign o_row_valid  = r_row_valid;
  assign o_row_data   = r_row_data;
  assign o_row_index  = r_row_index;
  assign o_frame_done = r_frame_done;
  assign o_lit_count  = r_lit_count;
  assign o_overrun    = r_overrun;

endmodule

// File: tb/tb_crt_frame_capture.sv
// -----------------------------------------------------------------------------
// tb_crt_frame_capture
// Purpose : randomized self-checking bench. The stimulus side feeds a frame
//           model that pushes expected rows and lit counts into queues; a
//           monitor pops and compares whenever the DUT hands out a row or
//           pulses frame_done.
// -----------------------------------------------------------------------------
module tb_crt_frame_capture;

  localparam int W = 40;
  localparam int H = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        pixel_valid;
  logic        pixel;
  logic        row_valid;
  logic        row_ready;
  logic [W-1:0] row_data;
  logic [2:0]  row_index;
  logic        frame_done;
  logic [8:0]  lit_count;
  logic        overrun;

  always #5 clk = ~clk;

  crt_frame_capture dut (
    .clk           (clk),
    .rst           (rst),
    .i_pixel_valid (pixel_valid),
    .i_pixel       (pixel),
    .o_row_valid   (row_valid),
    .i_row_ready   (row_ready),
    .o_row_data    (row_data),
    .o_row_index   (row_index),
    .o_frame_done  (frame_done),
    .o_lit_count   (lit_count),
    .o_overrun     (overrun)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [2:0]   idx;
    logic [W-1:0] data;
  } row_t;

  row_t exp_rows[$];
  int   exp_lit[$];

  // Reference model state: a plain 2-D picture plus a cursor.
  int           m_col, m_row, m_lit;
  logic [W-1:0] m_frame[H];
  bit           m_readout;
  bit           exp_overrun;
  int           m_frames = 0;

  int hs_count = 0;
  int fd_count = 0;
  int ready_mode = 1;   // 0 random, 1 always, 2 pattern 1,0,0, 3 never
  int crt_px[W*H];

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_col = 0; m_row = 0; m_lit = 0;
    m_readout = 0; exp_overrun = 0;
  endfunction

  function automatic void model_pixel(bit p);
    if (m_readout) begin
      exp_overrun = 1;
      return;
    end
    m_frame[m_row][W-1-m_col] = p;
    m_lit += int'(p);
    m_col++;
    if (m_col == W) begin
      m_col = 0;
      m_row++;
      if (m_row == H) begin
        m_row = 0;
        for (int r = 0; r < H; r++) exp_rows.push_back('{idx: 3'(r), data: m_frame[r]});
        exp_lit.push_back(m_lit);
        m_lit = 0;
        m_readout = 1;
        m_frames++;
      end
    end
  endfunction

  // AoC-style CRT: sprite at X covers X-1..X+1; noop = 1 cycle, addx = 2.
  function automatic void gen_crt();
    int x = 1, rem = 0, pend = 0, col;
    for (int c = 0; c < W*H; c++) begin
      if (rem == 0) begin
        if ($urandom_range(0, 1) == 1) begin
          rem = 2; pend = int'($urandom_range(0, 8)) - 4;
        end else begin
          rem = 1; pend = 0;
        end
      end
      col = c % W;
      crt_px[c] = (col >= x - 1 && col <= x + 1) ? 1 : 0;
      rem--;
      if (rem == 0) x += pend;
    end
  endfunction

  task automatic drive(bit v, bit p);
    @(posedge clk);
    #1;
    pixel_valid = v;
    pixel       = p;
    if (v) model_pixel(p);
  endtask

  // kind: 0 random, 1 edge columns, 2 CRT image, 3 all lit
  // gaps: idle cycles before each pixel, -1 = random 0..2
  task automatic send_frame(int kind, int gaps);
    bit p;
    int g;
    for (int i = 0; i < W*H; i++) begin
      g = (gaps < 0) ? int'($urandom_range(0, 2)) : gaps;
      repeat (g) drive(0, 0);
      case (kind)
        0: p = 1'($urandom_range(0, 1));
        1: p = ((i % W) == 0) || ((i % W) == W-1);
        2: p = 1'(crt_px[i]);
        default: p = 1'b1;
      endcase
      drive(1, p);
    end
    @(posedge clk);
    #1;
    pixel_valid = 1'b0;
    @(negedge clk);
    check("latency_row_valid", 64'(row_valid), 64'd1);
    check("frame_done_pulse", 64'(frame_done), 64'd1);
  endtask

  task automatic wait_readout(int target);
    int cyc = 0;
    while (hs_count < target && cyc < 3000) begin
      @(posedge clk);
      #1;
      pixel_valid = 1'b0;
      cyc++;
    end
    if (hs_count < target) begin
      n_checks++;
      n_errors++;
      $display("FAIL readout_timeout: got %0d handshakes expected %0d", hs_count, target);
    end
    m_readout = 0;
  endtask

  // Reader: drives row_ready according to ready_mode.
  initial begin
    int ph = 0;
    row_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: row_ready = 1'($urandom_range(0, 1));
        1: row_ready = 1'b1;
        2: begin row_ready = (ph % 3 == 0); ph++; end
        default: row_ready = 1'b0;
      endcase
    end
  end

  // Monitor / scoreboard.
  initial begin
    bit           prev_stall = 0;
    logic [W-1:0] prev_data  = '0;
    logic [2:0]   prev_idx   = '0;
    row_t         e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 0;
      end else begin
        if (prev_stall && row_valid) begin
          check("hold_data", 64'(row_data), 64'(prev_data));
          check("hold_index", 64'(row_index), 64'(prev_idx));
        end
        if (row_valid && row_ready) begin
          if (exp_rows.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL unexpected_row: got index %0d data %0h expected none", row_index, row_data);
          end else begin
            e = exp_rows.pop_front();
            check("row_index", 64'(row_index), 64'(e.idx));
            check("row_data", 64'(row_data), 64'(e.data));
          end
          hs_count++;
        end
        if (frame_done) begin
          fd_count++;
          if (exp_lit.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL unexpected_frame_done: got lit %0d expected none", lit_count);
          end else begin
            check("lit_count", 64'(lit_count), 64'(exp_lit.pop_front()));
          end
        end
        prev_stall = row_valid && !row_ready;
        prev_data  = row_data;
        prev_idx   = row_index;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fd_before;
    rst = 1'b1;
    pixel_valid = 1'b0;
    pixel = 1'b0;
    model_reset();
    gen_crt();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_row_valid", 64'(row_valid), 64'd0);
    check("rst_row_data", 64'(row_data), 64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    check("rst_lit_count", 64'(lit_count), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: partial row, asynchronous reset mid-cycle, then a full random frame.
    ready_mode = 1;
    for (int i = 0; i < 17; i++) drive(1, 1'($urandom_range(0, 1)));
    @(posedge clk);
    #1;
    pixel_valid = 1'b0;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("arst_row_index", 64'(row_index), 64'd0);
    check("arst_overrun", 64'(overrun), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    fd_before = fd_count;
    send_frame(0, -1);
    wait_readout(6);
    check("frame_done_once", 64'(fd_count), 64'(fd_before + 1));

    // 2: only the edge columns lit.
    send_frame(1, 0);
    wait_readout(12);

    // 3: CRT image, random reader back-pressure.
    ready_mode = 0;
    send_frame(2, 0);
    wait_readout(18);

    // 4: reader pattern 1,0,0 then back-to-back readout.
    ready_mode = 2;
    send_frame(0, -1);
    wait_readout(24);
    ready_mode = 1;
    send_frame(0, 0);
    for (int i = 1; i < 7; i++) begin
      @(negedge clk);
      check("b2b_row_valid", 64'(row_valid), (i < 6) ? 64'd1 : 64'd0);
    end
    wait_readout(30);

    // 5: pixels during readout set overrun and are dropped.
    ready_mode = 3;
    send_frame(0, 0);
    for (int i = 0; i < 10; i++) drive(1, 1'($urandom_range(0, 1)));
    @(posedge clk);
    #1;
    pixel_valid = 1'b0;
    @(negedge clk);
    check("overrun_set", 64'(overrun), 64'(exp_overrun));
    ready_mode = 1;
    wait_readout(36);

    // 6: all lit with 1-of-3 pixel duty; new frame must start at column 0.
    send_frame(3, 2);
    wait_readout(42);
    check("overrun_sticky", 64'(overrun), 64'(exp_overrun));

    repeat (3) @(posedge clk);
    check("rows_drained", 64'(exp_rows.size()), 64'd0);
    check("lits_drained", 64'(exp_lit.size()), 64'd0);
    check("frame_done_total", 64'(fd_count), 64'(m_frames));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
